instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Sequential reader for the byte-wide, combinational-read instruction memory. Holds the program
//   counter and drives the memory address. Builds each 16-bit instruction from two consecutive
//   bytes (high byte first) and presents it to the decoder on a valid/ready handshake.
//   Supports branch redirect and stops on the all-zero HALT word.
// PARAMETERS
//   ADDR_W     8       width of memory address / program counter
//   INSTR_W    16      instruction width; fixed at 2*8 bits (two memory bytes)
//   RESET_PC   8'h00   program counter value after reset
// PORTS
//   clk            in   1        single clock, rising edge
//   rst_n          in   1        asynchronous, active-low reset
//   address        out  ADDR_W   byte address to instruction memory
//   data           in   8        byte returned by memory for address, valid in the same cycle
//   instr          out  INSTR_W  assembled instruction {byte@pc, byte@pc+1}
//   instr_pc       out  ADDR_W   address of the first byte of instr
//   instr_valid    out  1        instr/instr_pc are valid
//   instr_ready    in   1        decoder accepts instr this cycle
//   branch_en      in   1        redirect fetch to branch_target
//   branch_target  in   ADDR_W   new program counter, any value (odd allowed)
//   halted         out  1        high while in HALTED state
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=FETCH_HI, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0,
//     halted=0, hi_byte=0. address is combinational from state/pc, so it equals RESET_PC during reset.
//   - address: pc in FETCH_HI; pc+1 (mod 2^ADDR_W) in FETCH_LO; pc in HOLD and HALTED.
//   - FETCH_HI: hi_byte<=data; next FETCH_LO.
//   - FETCH_LO: instr<={hi_byte,data}, instr_pc<=pc, instr_valid<=1, pc<=pc+2 (wraps mod 256);
//     next HOLD.
//   - HOLD: instr/instr_pc stay stable while instr_valid=1 and instr_ready=0.
//     On instr_ready=1: instr_valid<=0. If instr==16'h0000, next HALTED; otherwise next FETCH_HI.
//   - HALTED: halted=1, no fetch activity. Leave only by reset or branch_en.
//   - Latency: instr_valid rises on the 2nd edge after entering FETCH_HI.
//     Steady-state throughput: one instruction per 3 cycles when ready is held high.
//   - branch_en=1 (any state): pc<=branch_target, instr_valid<=0, halted<=0, next FETCH_HI.
//     Any partially built or held instruction is discarded.
//     Branch wins over an instr_ready in the same cycle: that instruction is NOT accepted.
//   - Wrap-around: pc=8'hFF fetches bytes FF then 00; pc then becomes 8'h01.
//   - Reset mid-operation: all state returns to reset values immediately; a held instruction is lost.
//   - instr_ready while instr_valid=0 is ignored.
// STRUCTURE
//   - Shared package fetch_pkg:
//     - state enum (FETCH_HI, FETCH_LO, HOLD, HALTED, 2 bits)
//     - HALT_OPCODE = 16'h0000
//     - INSTR_BYTES = 2
//   - Single module, no sub-modules. The pc register and next-pc adder are small enough to stay inline.
//   - Bench instantiates the existing instruction memory as the data source.
// TESTING
//   1. Reset, preload mem[0..3]=03,45,04,65, ready=1
//      -> instr=16'h0345 (pc 00), then 16'h0465 (pc 02); valid pulses every 3 cycles.
//   2. Hold ready=0 for 5 cycles while valid
//      -> instr, instr_pc and valid stay stable; pc stays 02; next fetch starts only after ready=1.
//   3. branch_en=1, target=8'h0C during FETCH_LO
//      -> partial word dropped; next instr=16'h07D5 with instr_pc=0C, bytes taken from 0C/0D.
//   4. Fetch reaches mem[14..15]=0000, then ready=1
//      -> halted=1 the next cycle, address frozen, no further valid;
//      a later branch to 8'h00 restarts the fetch and gives 16'h0345.
//   5. Branch to 8'hFF with mem[FF]=AA, mem[00]=03
//      -> instr=16'hAA03, instr_pc=FF; next fetch at pc=01.
//   6. Deassert rst_n while in HOLD with valid=1
//      -> valid drops asynchronously; after release, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2,
    HALTED   = 2'd3
  } fetch_state_e;

  localparam logic [15:0] HALT_OPCODE = 16'h0000;
  localparam int          INSTR_BYTES = 2;
endpackage

// File: rtl/instr_fetch_unit.sv
// Sequential byte-wide instruction fetcher: builds 16-bit words high byte first and
// offers them on a valid/ready handshake, with branch redirect and HALT detection.
//
// state    | meaning
// FETCH_HI | address=pc, capture high byte
// FETCH_LO | address=pc+1, assemble word, raise valid, advance pc
// HOLD     | word presented, wait for ready
// HALTED   | HALT word accepted, idle until branch or reset
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter int                 INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  address,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [7:0]         hi_byte_q, hi_byte_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_HI;
      pc_q          <= RESET_PC;
      hi_byte_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hi_byte_q     <= hi_byte_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    address = pc_q;
    if (state_q == FETCH_LO) address = pc_q + ADDR_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hi_byte_d     = hi_byte_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    // Branch overrides everything, including a same-cycle accept in HOLD.
    if (branch_en) begin
      pc_d          = branch_target;
      instr_valid_d = 1'b0;
      state_d       = FETCH_HI;
    end else begin
      case (state_q)
        FETCH_HI: begin
          hi_byte_d = data;
          state_d   = FETCH_LO;
        end
        FETCH_LO: begin
          instr_d       = {hi_byte_q, data};
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + ADDR_W'(INSTR_BYTES);
          state_d       = HOLD;
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            state_d = (instr_q == INSTR_W'(HALT_OPCODE)) ? HALTED : FETCH_HI;
          end
        end
        HALTED: ;
        default: state_d = FETCH_HI;
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver pushes expected words, a negedge
// monitor pops and compares every accepted instruction.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  address;
  logic [7:0]  data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic        halted;

  logic [7:0] mem [0:255];
  assign data = mem[address];

  typedef struct packed {
    logic [15:0] w;
    logic [7:0]  pc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data(data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_en(branch_en),
    .branch_target(branch_target), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    check(name, {15'd0, instr_valid}, 16'd1);
  endtask

  task automatic push(input logic [15:0] w, input logic [7:0] pc);
    exp_t e;
    e.w = w;
    e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: an instruction is accepted only when no branch is present.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !branch_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept got %h@%h expected none", instr, instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_instr", instr, e.w);
        check("sb_pc", {8'd0, instr_pc}, {8'd0, e.pc});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h80 | 8'(i);
    mem[8'h00] = 8'h03; mem[8'h01] = 8'h45; mem[8'h02] = 8'h04; mem[8'h03] = 8'h65;
    mem[8'h0C] = 8'h07; mem[8'h0D] = 8'hD5;
    mem[8'h0E] = 8'h11; mem[8'h0F] = 8'h22; mem[8'h10] = 8'h33; mem[8'h11] = 8'h44;
    mem[8'h12] = 8'h55; mem[8'h13] = 8'h66; mem[8'h14] = 8'h00; mem[8'h15] = 8'h00;
    mem[8'hFF] = 8'hAA;

    rst_n = 1'b0; instr_ready = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
    #12;
    check("rst_address", {8'd0, address}, 16'h0000);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", {8'd0, instr_pc}, 16'h0000);

    // 1: sequential fetch with ready high
    push(16'h0345, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1; instr_ready = 1'b1;
    check("t1_addr_hi", {8'd0, address}, 16'h0000);
    tick();
    check("t1_addr_lo", {8'd0, address}, 16'h0001);
    tick();
    check("t1_latency", {15'd0, instr_valid}, 16'd1);
    tick();
    instr_ready = 1'b0;
    check("t1_valid_drop", {15'd0, instr_valid}, 16'd0);

    // 2: backpressure holds the second word stable
    wait_valid("t2_wait", 10);
    for (int i = 0; i < 5; i++) begin
      check("t2_instr", instr, 16'h0465);
      check("t2_instr_pc", {8'd0, instr_pc}, 16'h0002);
      check("t2_valid", {15'd0, instr_valid}, 16'd1);
      check("t2_addr", {8'd0, address}, 16'h0004);
      tick();
    end
    push(16'h0465, 8'h02);
    instr_ready = 1'b1;
    tick();
    check("t2_next_fetch", {8'd0, address}, 16'h0004);
    check("t2_valid_low", {15'd0, instr_valid}, 16'd0);

    // 3: branch during FETCH_LO drops the partial word
    tick();
    check("t3_in_lo", {8'd0, address}, 16'h0005);
    branch_en = 1'b1; branch_target = 8'h0C;
    tick();
    branch_en = 1'b0;
    check("t3_redirect", {8'd0, address}, 16'h000C);
    check("t3_no_valid", {15'd0, instr_valid}, 16'd0);
    push(16'h07D5, 8'h0C);
    push(16'h1122, 8'h0E);
    push(16'h3344, 8'h10);
    push(16'h5566, 8'h12);
    push(16'h0000, 8'h14);

    // 4: HALT word stops fetching
    for (int n = 0; n < 60 && !halted; n++) tick();
    check("t4_halted", {15'd0, halted}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      check("t4_addr_frozen", {8'd0, address}, 16'h0016);
      check("t4_no_valid", {15'd0, instr_valid}, 16'd0);
      tick();
    end
    branch_en = 1'b1; branch_target = 8'h00;
    tick();
    branch_en = 1'b0;
    check("t4_unhalt", {15'd0, halted}, 16'd0);
    check("t4_restart_addr", {8'd0, address}, 16'h0000);
    push(16'h0345, 8'h00);
    wait_valid("t4_wait", 10);
    tick();

    // 5: wrap-around fetch at FF
    branch_en = 1'b1; branch_target = 8'hFF;
    tick();
    branch_en = 1'b0;
    check("t5_addr_ff", {8'd0, address}, 16'h00FF);
    push(16'hAA03, 8'hFF);
    tick();
    check("t5_addr_wrap", {8'd0, address}, 16'h0000);
    wait_valid("t5_wait", 10);
    check("t5_pc_after", {8'd0, address}, 16'h0001);
    tick();
    instr_ready = 1'b0;
    check("t5_next_fetch", {8'd0, address}, 16'h0001);

    // branch beats a same-cycle ready on a held word
    wait_valid("tb_wait", 10);
    check("tb_held", instr, 16'h4504);
    instr_ready = 1'b1; branch_en = 1'b1; branch_target = 8'h0C;
    tick();
    branch_en = 1'b0; instr_ready = 1'b0;
    check("tb_dropped", {15'd0, instr_valid}, 16'd0);
    check("tb_addr", {8'd0, address}, 16'h000C);

    // 6: async reset while holding
    wait_valid("t6_wait", 10);
    check("t6_held", instr, 16'h07D5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid_async", {15'd0, instr_valid}, 16'd0);
    check("t6_addr_rst", {8'd0, address}, 16'h0000);
    check("t6_instr_rst", instr, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1; instr_ready = 1'b1;
    push(16'h0345, 8'h00);
    wait_valid("t6_refetch", 10);
    tick();
    tick();

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
